// File: rtl/psw_store.sv
// psw_store: password storage and compare stage fed by the Controller FSM.
// mem holds the set password, buff holds the attempt being keyed in.
// Digits shift in at the LSB end, so the newest digit always sits in the LSBs.
// Optional feature macro: PSW_BACKSPACE_EN adds the del_in port (drop newest buff digit).
// Command semantics: every *_sl / *_rst / del_in is a single-cycle level command
// sampled at the rising clock edge; there is no handshake and no backpressure.
module psw_store #(
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned MAX_LEN    = 8,
    parameter int unsigned MASTER_LEN = 6,
    parameter logic [MAX_LEN*DIGIT_W-1:0] MASTER_PSW = (MAX_LEN*DIGIT_W)'(24'h123456)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               mem_sl,
    input  logic               buff_sl,
    input  logic               mem_rst,
    input  logic               buff_rst,
`ifdef PSW_BACKSPACE_EN
    input  logic               del_in,
`endif
    output logic               same,
    output logic               master_same,
    output logic               mem_limit,
    output logic               buff_limit
);

    localparam int unsigned REG_W = MAX_LEN * DIGIT_W;
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] FULL_LEN   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MASTER_CNT = LEN_W'(MASTER_LEN);

    // Master digits with every slot above MASTER_LEN forced to zero, so the
    // compare against buff_reg can be a whole-vector equality.
    function automatic logic [REG_W-1:0] master_vec();
        logic [REG_W-1:0] v;
        for (int i = 0; i < REG_W; i++) begin
            v[i] = (i < MASTER_LEN * DIGIT_W) ? MASTER_PSW[i] : 1'b0;
        end
        return v;
    endfunction

    localparam logic [REG_W-1:0] MASTER_VEC = master_vec();

    logic [REG_W-1:0] r_mem_reg;
    logic [REG_W-1:0] r_buff_reg;
    logic [LEN_W-1:0] r_mem_len;
    logic [LEN_W-1:0] r_buff_len;

    logic w_mem_full;
    logic w_buff_full;

    assign w_mem_full  = (r_mem_len == FULL_LEN);
    assign w_buff_full = (r_buff_len == FULL_LEN);

    // mem store: clear wins over load; a load into a full store is ignored.
    always_ff @(posedge clk) begin
        if (rst || mem_rst) begin
            r_mem_reg <= '0;
            r_mem_len <= '0;
        end else if (mem_sl && !w_mem_full) begin
            r_mem_reg <= {r_mem_reg[REG_W-DIGIT_W-1:0], digit_in};
            r_mem_len <= r_mem_len + 1'b1;
        end
    end

    // buff store: clear > backspace (if built) > load; full store ignores loads.
    always_ff @(posedge clk) begin
        if (rst || buff_rst) begin
            r_buff_reg <= '0;
            r_buff_len <= '0;
`ifdef PSW_BACKSPACE_EN
        end else if (del_in) begin
            // A coincident load digit is dropped, even when buff is already empty.
            if (r_buff_len != '0) begin
                r_buff_reg <= {{DIGIT_W{1'b0}}, r_buff_reg[REG_W-1:DIGIT_W]};
                r_buff_len <= r_buff_len - 1'b1;
            end
`endif
        end else if (buff_sl && !w_buff_full) begin
            r_buff_reg <= {r_buff_reg[REG_W-DIGIT_W-1:0], digit_in};
            r_buff_len <= r_buff_len + 1'b1;
        end
    end

    // Status flags are pure decodes of the registered stores.
    always_comb begin
        mem_limit   = w_mem_full;
        buff_limit  = w_buff_full;
        same        = (r_buff_len == r_mem_len) && (r_buff_reg == r_mem_reg) &&
                      (r_mem_len != '0);
        master_same = (r_buff_len == MASTER_CNT) && (r_buff_reg == MASTER_VEC);
    end

endmodule

// File: tb/tb_psw_store.sv
// tb_psw_store: directed self-checking bench for psw_store (default parameters).
// Build with +define+PSW_BACKSPACE_EN to also exercise the backspace path.
module tb_psw_store;

    logic       clk;
    logic       rst;
    logic [3:0] digit_in;
    logic       mem_sl;
    logic       buff_sl;
    logic       mem_rst;
    logic       buff_rst;
    logic       del_in;
    logic       same;
    logic       master_same;
    logic       mem_limit;
    logic       buff_limit;

    int n_tests;
    int n_fail;

    psw_store dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .mem_sl      (mem_sl),
        .buff_sl     (buff_sl),
        .mem_rst     (mem_rst),
        .buff_rst    (buff_rst),
`ifdef PSW_BACKSPACE_EN
        .del_in      (del_in),
`endif
        .same        (same),
        .master_same (master_same),
        .mem_limit   (mem_limit),
        .buff_limit  (buff_limit)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: hold one command set across one rising edge, then sample #1 after it
    task automatic step(input logic ms, input logic bs, input logic mr, input logic br,
                        input logic dl, input logic [3:0] d);
        mem_sl   = ms;
        buff_sl  = bs;
        mem_rst  = mr;
        buff_rst = br;
        del_in   = dl;
        digit_in = d;
        @(posedge clk);
        #1;
        mem_sl   = 1'b0;
        buff_sl  = 1'b0;
        mem_rst  = 1'b0;
        buff_rst = 1'b0;
        del_in   = 1'b0;
        digit_in = 4'd0;
    endtask

    task automatic load_mem(input logic [3:0] d);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic load_buff(input logic [3:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic clear_both();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        mem_sl   = 1'b0;
        buff_sl  = 1'b0;
        mem_rst  = 1'b0;
        buff_rst = 1'b0;
        del_in   = 1'b0;
        digit_in = 4'd0;

        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_same",        32'(same),        32'd0);
        check("rst_master_same", 32'(master_same), 32'd0);
        check("rst_mem_limit",   32'(mem_limit),   32'd0);
        check("rst_buff_limit",  32'(buff_limit),  32'd0);

        // 2: equal 4-digit passwords, then one extra buff digit
        for (int i = 1; i <= 4; i++) load_mem(4'(i));
        for (int i = 1; i <= 3; i++) load_buff(4'(i));
        check("same_partial", 32'(same), 32'd0);
        load_buff(4'd4);
        check("same_1234", 32'(same), 32'd1);
        load_buff(4'd5);
        check("same_after_extra", 32'(same), 32'd0);

        // 3: fill mem to capacity, overflow load must be ignored
        clear_both();
        for (int i = 1; i <= 7; i++) load_mem(4'(i));
        check("mem_limit_7", 32'(mem_limit), 32'd0);
        load_mem(4'd8);
        check("mem_limit_8", 32'(mem_limit), 32'd1);
        load_mem(4'd9);
        check("mem_limit_hold", 32'(mem_limit), 32'd1);
        for (int i = 1; i <= 8; i++) load_buff(4'(i));
        check("buff_limit_8", 32'(buff_limit), 32'd1);
        check("same_no_overwrite", 32'(same), 32'd1);
        load_buff(4'd9);
        check("same_buff_overflow", 32'(same), 32'd1);
        // clear and load together: clear wins, digit dropped
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        check("mem_limit_rst_sl", 32'(mem_limit), 32'd0);
        check("same_mem_empty", 32'(same), 32'd0);
        // mem_sl and buff_rst together: independent stores
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        check("buff_limit_cleared", 32'(buff_limit), 32'd0);
        load_buff(4'd6);
        check("same_len_after_rst_sl", 32'(same), 32'd1);

        // 4: master password
        clear_both();
        for (int i = 1; i <= 5; i++) load_buff(4'(i));
        check("master_partial", 32'(master_same), 32'd0);
        load_buff(4'd6);
        check("master_same", 32'(master_same), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("master_after_rst", 32'(master_same), 32'd0);
        check("buff_limit_after_rst", 32'(buff_limit), 32'd0);
        for (int i = 1; i <= 7; i++) load_buff(4'(i));
        check("master_too_long", 32'(master_same), 32'd0);

        // 5: both empty, then simultaneous load
        clear_both();
        check("same_both_empty", 32'(same), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7);
        check("same_sim_7", 32'(same), 32'd1);
        // digits above 9 are stored as-is
        clear_both();
        load_mem(4'd15);
        load_buff(4'd14);
        check("same_14_vs_15", 32'(same), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        load_buff(4'd15);
        check("same_15", 32'(same), 32'd1);

`ifdef PSW_BACKSPACE_EN
        // 6: backspace
        clear_both();
        for (int i = 1; i <= 4; i++) load_mem(4'(i));
        for (int i = 1; i <= 5; i++) load_buff(4'(i));
        check("del_pre", 32'(same), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("del_same", 32'(same), 32'd1);
        // del with coincident load: load digit dropped
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
        check("del_sl_drop", 32'(same), 32'd0);
        load_buff(4'd4);
        check("del_sl_restore", 32'(same), 32'd1);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("del_empty", 32'(same), 32'd0);
        for (int i = 1; i <= 4; i++) load_buff(4'(i));
        check("del_no_underflow", 32'(same), 32'd1);
        // clear beats del
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        load_buff(4'd1);
        check("rst_over_del", 32'(same), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
